// File: rtl/jk_excitation_sequencer_if.sv
// Target stream and JK bank connection for the excitation sequencer.
// The sequencer takes the slave side; the environment (bank and producer) takes the master side.
interface jk_excitation_sequencer_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] tgt_data;
    logic             tgt_valid;
    logic             tgt_ready;
    logic [WIDTH-1:0] q_fb;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;

    modport master (
        output tgt_data, tgt_valid, q_fb,
        input  tgt_ready, j, k
    );

    modport slave (
        input  tgt_data, tgt_valid, q_fb,
        output tgt_ready, j, k
    );
endinterface

// File: rtl/jk_excitation_sequencer.sv
// Drives an external JK flip-flop bank through a queue of target words.
// Each target gets one cycle of J/K excitation followed by a Q read-back check.
module jk_excitation_sequencer #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int XMODE = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    jk_excitation_sequencer_if.slave bus,
    output logic                     o_busy,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_done,
    output logic                     o_err,
    output logic [WIDTH-1:0]         o_err_bits
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, APPLY, CHECK, HALT} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_tgt;
    logic [WIDTH-1:0] r_j;
    logic [WIDTH-1:0] r_k;
    logic             r_done;
    logic             r_err;
    logic [WIDTH-1:0] r_err_bits;

    logic             w_push;
    logic             w_pop;
    logic             w_match;
    logic             w_done_nxt;
    logic             w_err_set;
    logic [WIDTH-1:0] w_head;
    logic [WIDTH-1:0] w_j_nxt;
    logic [WIDTH-1:0] w_k_nxt;

    assign w_head        = r_mem[r_rptr];
    assign bus.tgt_ready = (r_count != FULL);
    assign w_push        = bus.tgt_valid & bus.tgt_ready;
    assign w_match       = (bus.q_fb == r_tgt);

    assign bus.j      = r_j;
    assign bus.k      = r_k;
    assign o_busy     = (r_state != IDLE);
    assign o_count    = r_count;
    assign o_done     = r_done;
    assign o_err      = r_err;
    assign o_err_bits = r_err_bits;

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_count != '0) begin
                    w_pop       = 1'b1;
                    w_state_nxt = APPLY;
                end
            end
            APPLY: w_state_nxt = CHECK;
            CHECK: begin
                if (w_match) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_err_set   = 1'b1;
                    w_state_nxt = HALT;
                end
            end
            HALT:    w_state_nxt = HALT;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Closed forms of the excitation table; XMODE picks how the X entries resolve.
    always_comb begin
        w_j_nxt = '0;
        w_k_nxt = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (XMODE == 0) begin
                w_j_nxt[i] = ~bus.q_fb[i] & w_head[i];
                w_k_nxt[i] = bus.q_fb[i] & ~w_head[i];
            end else begin
                w_j_nxt[i] = bus.q_fb[i] | w_head[i];
                w_k_nxt[i] = ~(bus.q_fb[i] & w_head[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= bus.tgt_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // J/K are loaded only on the pop, so they are non-zero exactly during APPLY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_tgt      <= '0;
            r_j        <= '0;
            r_k        <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_bits <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_j     <= w_pop ? w_j_nxt : '0;
            r_k     <= w_pop ? w_k_nxt : '0;
            r_done  <= w_done_nxt;
            if (w_pop) begin
                r_tgt <= w_head;
            end
            if (w_err_set) begin
                r_err      <= 1'b1;
                r_err_bits <= bus.q_fb ^ r_tgt;
            end
        end
    end
endmodule
